ddr4_req_scheduler: RTL

DDR4_REQ_SCHEDULER -- requirements
Module: ddr4_req_scheduler

---
 rtl/ddr4_req_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ddr4_req_scheduler.sv
// rtl/ddr4_req_scheduler.sv - in-order host request FIFO feeding a single-outstanding DDR4 command scheduler
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   host_valid/host_ready      request handshake; entry = {host_we, host_bg, host_addr, host_wdata}
//   ctrl_addr/wdata/bg_en      command fields, held stable while an enable is high
//   ctrl_write_en/read_en      one-hot command enables (never both)
//   ctrl_ready, ctrl_rdata     controller completion and read data
//   rsp_valid, rsp_data        one-cycle read-response strobe and its data
//   err_timeout                one-cycle strobe when a command is dropped for lack of ctrl_ready
//   fifo_count                 current FIFO occupancy
module ddr4_req_scheduler #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   host_we,
  input  logic [31:0]            host_addr,
  input  logic [15:0]            host_wdata,
  input  logic [1:0]             host_bg,
  output logic [31:0]            ctrl_addr,
  output logic [15:0]            ctrl_wdata,
  output logic [1:0]             ctrl_bg_en,
  output logic                   ctrl_write_en,
  output logic                   ctrl_read_en,
  input  logic                   ctrl_ready,
  input  logic [15:0]            ctrl_rdata,
  output logic                   rsp_valid,
  output logic [15:0]            rsp_data,
  output logic                   err_timeout,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 51;
  // The counter starts at 0 on the first WAIT cycle, so TIMEOUT-1 marks the last allowed WAIT cycle.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t        state, state_nxt;
  logic [EW-1:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, wait_done, wait_tmo;
  logic          cur_we;
  logic [15:0]   tcnt;

  assign host_ready = (fifo_count < CW'(DEPTH));
  assign push       = host_valid && host_ready;

  // Storage only; occupancy and pointers carry the reset state.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {host_we, host_bg, host_addr, host_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Enables decode straight from the state register so an asynchronous reset drops them at once.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    wait_done     = 1'b0;
    wait_tmo      = 1'b0;
    ctrl_write_en = 1'b0;
    ctrl_read_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_count != '0) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ctrl_write_en = cur_we;
        ctrl_read_en  = !cur_we;
        state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        ctrl_write_en = cur_we;
        ctrl_read_en  = !cur_we;
        // Ready wins over an expiring counter in the same cycle.
        if (ctrl_ready) begin
          wait_done = 1'b1;
          state_nxt = S_GAP;
        end else if (tcnt == TMO_LAST) begin
          wait_tmo  = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_we      <= 1'b0;
      ctrl_bg_en  <= '0;
      ctrl_addr   <= '0;
      ctrl_wdata  <= '0;
      tcnt        <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (pop) begin
        {cur_we, ctrl_bg_en, ctrl_addr, ctrl_wdata} <= fifo_mem[rd_ptr];
      end
      if (state == S_ISSUE) begin
        tcnt <= '0;
      end else if (state == S_WAIT) begin
        tcnt <= tcnt + 16'd1;
      end
      rsp_valid   <= wait_done && !cur_we;
      err_timeout <= wait_tmo;
      if (wait_done && !cur_we) begin
        rsp_data <= ctrl_rdata;
      end
    end
  end

endmodule
